// File: rtl/cplx_mult_top.sv
// rtl/cplx_mult_top.sv - APB-programmed complex multiplier streaming operands from and results to a 1RW byte memory
// Optional feature macro: CMULT_SLVERR_EN (out-of-range APB accesses assert apb_pslverr)
module cplx_mult_top #(
    parameter int DWIDTH    = 8,
    parameter int NO_MULT   = 4,
    parameter int APB_BADDR = 1024,
    parameter int SYS_AW    = 16,
    parameter int REG_DW    = 16
) (
    input  logic              clk,
    input  logic              sw_rst,
    input  logic [SYS_AW-1:0] apb_paddr,
    input  logic              apb_pwrite,
    input  logic [REG_DW-1:0] apb_pwdata,
    input  logic              apb_psel,
    output logic              apb_pready,
    output logic [REG_DW-1:0] apb_prdata,
    output logic              apb_pslverr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [SYS_AW-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wr_data,
    input  logic [DWIDTH-1:0] mem_rd_data
);

    localparam int MUL_CYC = 4 / NO_MULT;
    localparam int PW      = 2 * DWIDTH;
    localparam logic [SYS_AW-1:0] BASE = SYS_AW'(APB_BADDR);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MUL  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state;
    logic [2:0]         cnt;
    logic [SYS_AW-1:0]  op1_ba, op2_ba, res_ba;
    logic [REG_DW-1:0]  nr_op;
    logic               sts_stop;

    logic [SYS_AW-1:0]  op1_ptr, op2_ptr, wr_ptr;
    logic [REG_DW-1:0]  ops_left;
    logic signed [DWIDTH-1:0] x1, y1, x2, y2;
    logic signed [PW-1:0] p [4];
    logic signed [PW-1:0] pn [4];
    logic signed [PW-1:0] prod [NO_MULT];
    logic [1:0]         mul_idx [NO_MULT];
    logic signed [23:0] xr_n, yr_n;
    logic [47:0]        res_sh;

    logic [SYS_AW-1:0]  offset;
    logic               in_range, wr_en, start_req, stop_wr;
    logic [REG_DW-1:0]  rd_val;

    assign offset    = apb_paddr - BASE;
    assign in_range  = (apb_paddr >= BASE) && (offset < SYS_AW'(7));
    assign wr_en     = apb_psel && apb_pwrite && in_range;
    assign start_req = wr_en && (offset == SYS_AW'(4)) && apb_pwdata[0];
    assign stop_wr   = wr_en && (offset == SYS_AW'(5));

    function automatic logic signed [23:0] sext(input logic signed [PW-1:0] v);
        return {{(24-PW){v[PW-1]}}, v};
    endfunction

    // Product slot j of MUL cycle cnt handles index cnt*NO_MULT+j: 0=x1x2 1=y1y2 2=x1y2 3=y1x2
    for (genvar j = 0; j < NO_MULT; j++) begin : g_mul
        logic signed [DWIDTH-1:0] a, b;
        assign mul_idx[j] = 2'(int'(cnt) * NO_MULT + j);
        assign a = (mul_idx[j] == 2'd0 || mul_idx[j] == 2'd2) ? x1 : y1;
        assign b = (mul_idx[j] == 2'd0 || mul_idx[j] == 2'd3) ? x2 : y2;
        assign prod[j] = PW'(a) * PW'(b);
    end

    // Merge this cycle's products so the final MUL cycle can form results without an extra stage
    always_comb begin
        for (int i = 0; i < 4; i++) pn[i] = p[i];
        for (int j = 0; j < NO_MULT; j++) pn[mul_idx[j]] = prod[j];
        xr_n = sext(pn[0]) - sext(pn[1]);
        yr_n = sext(pn[2]) + sext(pn[3]);
    end

    // Register read mux; out-of-range offsets read as zero
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            case (offset[2:0])
                3'd0:    rd_val = REG_DW'(op1_ba);
                3'd1:    rd_val = REG_DW'(op2_ba);
                3'd2:    rd_val = REG_DW'(res_ba);
                3'd3:    rd_val = nr_op;
                3'd5:    rd_val = REG_DW'(sts_stop);
                3'd6:    rd_val = REG_DW'(state);
                default: rd_val = '0;
            endcase
        end
    end

    // APB register writes and the registered one-cycle response
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            apb_pready  <= 1'b0;
            apb_prdata  <= '0;
            apb_pslverr <= 1'b0;
            op1_ba      <= '0;
            op2_ba      <= '0;
            res_ba      <= '0;
            nr_op       <= '0;
        end else begin
            apb_pready <= apb_psel;
            apb_prdata <= (apb_psel && !apb_pwrite) ? rd_val : '0;
`ifdef CMULT_SLVERR_EN
            apb_pslverr <= apb_psel && !in_range;
`else
            apb_pslverr <= 1'b0;
`endif
            if (wr_en) begin
                case (offset[2:0])
                    3'd0:    op1_ba <= apb_pwdata[SYS_AW-1:0];
                    3'd1:    op2_ba <= apb_pwdata[SYS_AW-1:0];
                    3'd2:    res_ba <= apb_pwdata[SYS_AW-1:0];
                    3'd3:    nr_op  <= apb_pwdata;
                    default: ;
                endcase
            end
        end
    end

    // Operation sequencer: RD (4 reads + capture), MUL, WR (6 bytes), DONE; memory port driven from registers
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            op1_ptr     <= '0;
            op2_ptr     <= '0;
            wr_ptr      <= '0;
            ops_left    <= '0;
            x1          <= '0;
            y1          <= '0;
            x2          <= '0;
            y2          <= '0;
            for (int i = 0; i < 4; i++) p[i] <= '0;
            res_sh      <= '0;
            sts_stop    <= 1'b0;
        end else begin
            if (stop_wr) sts_stop <= apb_pwdata[0];
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        sts_stop <= 1'b0;
                        op1_ptr  <= op1_ba;
                        op2_ptr  <= op2_ba;
                        wr_ptr   <= res_ba;
                        ops_left <= nr_op;
                        cnt      <= '0;
                        if (nr_op == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_RD;
                            mem_ce   <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= op1_ba;
                        end
                    end
                end
                S_RD: begin
                    cnt <= cnt + 3'd1;
                    case (cnt)
                        3'd0: mem_addr <= op1_ptr + SYS_AW'(1);
                        3'd1: begin
                            mem_addr <= op2_ptr;
                            x1       <= mem_rd_data;
                        end
                        3'd2: begin
                            mem_addr <= op2_ptr + SYS_AW'(1);
                            y1       <= mem_rd_data;
                        end
                        3'd3: begin
                            mem_ce <= 1'b0;
                            x2     <= mem_rd_data;
                        end
                        default: begin
                            y2      <= mem_rd_data;
                            op1_ptr <= op1_ptr + SYS_AW'(2);
                            op2_ptr <= op2_ptr + SYS_AW'(2);
                            cnt     <= '0;
                            state   <= S_MUL;
                        end
                    endcase
                end
                S_MUL: begin
                    for (int i = 0; i < 4; i++) p[i] <= pn[i];
                    if (cnt == 3'(MUL_CYC - 1)) begin
                        state       <= S_WR;
                        cnt         <= '0;
                        mem_ce      <= 1'b1;
                        mem_we      <= 1'b1;
                        mem_addr    <= wr_ptr;
                        mem_wr_data <= DWIDTH'(xr_n[7:0]);
                        res_sh      <= {8'h00, yr_n, xr_n[23:8]};
                        wr_ptr      <= wr_ptr + SYS_AW'(1);
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WR: begin
                    if (cnt != 3'd5) begin
                        cnt         <= cnt + 3'd1;
                        mem_addr    <= wr_ptr;
                        mem_wr_data <= DWIDTH'(res_sh[7:0]);
                        res_sh      <= res_sh >> 8;
                        wr_ptr      <= wr_ptr + SYS_AW'(1);
                    end else begin
                        cnt      <= '0;
                        mem_we   <= 1'b0;
                        ops_left <= ops_left - REG_DW'(1);
                        if (ops_left == REG_DW'(1)) begin
                            mem_ce <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            mem_ce   <= 1'b1;
                            mem_addr <= op1_ptr;
                            state    <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    sts_stop <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_mult_top.sv
// tb/tb_cplx_mult_top.sv - self-checking bench for cplx_mult_top against an arithmetic reference model
module tb_cplx_mult_top;

    parameter int NM = 4;
    localparam int M    = 4 / NM;
    localparam int P    = 11 + M;
    localparam int BASE = 1024;
`ifdef CMULT_SLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sw_rst;
    logic [15:0] apb_paddr;
    logic        apb_pwrite;
    logic [15:0] apb_pwdata;
    logic        apb_psel;
    logic        apb_pready;
    logic [15:0] apb_prdata;
    logic        apb_pslverr;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data = 8'h00;

    always #5 clk = ~clk;

    cplx_mult_top #(.NO_MULT(NM)) dut (
        .clk(clk), .sw_rst(sw_rst),
        .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
        .apb_psel(apb_psel), .apb_pready(apb_pready), .apb_prdata(apb_prdata),
        .apb_pslverr(apb_pslverr),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (mem_ce && mem_we) mem[mem_addr] <= mem_wr_data;
        if (mem_ce && !mem_we) mem_rd_data <= mem[mem_addr];
    end

    typedef struct { int cyc; logic [15:0] addr; logic we; } acc_t;
    acc_t acc_log[$];
    acc_t mon_e;
    int   cyc = 0;
    int   start_cyc = -1;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) begin
        if (mem_ce) begin
            mon_e.cyc = cyc; mon_e.addr = mem_addr; mon_e.we = mem_we;
            acc_log.push_back(mon_e);
        end
        if (apb_psel && apb_pwrite && apb_paddr == 16'(BASE + 4) && apb_pwdata[0]) start_cyc = cyc;
        cyc <= cyc + 1;
    end

    task automatic apb_xfer(input logic wr, input int off, input logic [15:0] wd,
                            output logic [15:0] rd, output logic rdy, output logic err);
        apb_paddr = 16'(BASE + off); apb_pwrite = wr; apb_pwdata = wd; apb_psel = 1'b1;
        @(negedge clk);
        rd = apb_prdata; rdy = apb_pready; err = apb_pslverr;
        apb_psel = 1'b0; apb_pwrite = 1'b0; apb_pwdata = '0;
    endtask

    task automatic apb_write(input int off, input logic [15:0] wd);
        logic [15:0] d; logic r, e;
        apb_xfer(1'b1, off, wd, d, r, e);
    endtask

    task automatic apb_read(input int off, output logic [15:0] d);
        logic r, e;
        apb_xfer(1'b0, off, 16'h0, d, r, e);
    endtask

    task automatic program_run(input int a1, input int a2, input int ar, input int n);
        apb_write(0, 16'(a1)); apb_write(1, 16'(a2)); apb_write(2, 16'(ar)); apb_write(3, 16'(n));
        acc_log.delete();
        apb_write(4, 16'h1);
    endtask

    function automatic logic [47:0] ref_res(input int a1, input int a2);
        int x1, y1, x2, y2, xr, yr;
        x1 = int'($signed(mem[a1])); y1 = int'($signed(mem[a1 + 1]));
        x2 = int'($signed(mem[a2])); y2 = int'($signed(mem[a2 + 1]));
        xr = x1 * x2 - y1 * y2;
        yr = x1 * y2 + y1 * x2;
        return {yr[23:0], xr[23:0]};
    endfunction

    task automatic test_reset();
        logic [15:0] d; logic r, e;
        sw_rst = 1'b1; apb_psel = 1'b0; apb_pwrite = 1'b0; apb_paddr = '0; apb_pwdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({apb_pready, apb_pslverr, apb_prdata} !== 18'h0) begin
            errors++; $display("FAIL reset_apb got %h want 0", {apb_pready, apb_pslverr, apb_prdata});
        end
        checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wr_data} !== 26'h0) begin
            errors++; $display("FAIL reset_mem got %h want 0", {mem_ce, mem_we, mem_addr, mem_wr_data});
        end
        sw_rst = 1'b0;
        for (int off = 0; off < 7; off++) begin
            apb_xfer(1'b0, off, 16'h0, d, r, e);
            checks++;
            if (d !== 16'h0 || r !== 1'b1 || e !== 1'b0) begin
                errors++; $display("FAIL reset_reg%0d got d=%h rdy=%b err=%b want d=0 rdy=1 err=0", off, d, r, e);
            end
        end
    endtask

    task automatic test_regs();
        logic [15:0] d; logic r, e;
        int vals[5] = '{100, 200, 300, 10, 0};
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b1, i, 16'(vals[i]), d, r, e);
            checks++;
            if (r !== 1'b1 || d !== 16'h0) begin
                errors++; $display("FAIL wr_resp%0d got rdy=%b d=%h want rdy=1 d=0", i, r, d);
            end
        end
        for (int i = 0; i < 5; i++) begin
            apb_read(i, d);
            checks++;
            if (d !== 16'(vals[i])) begin
                errors++; $display("FAIL readback%0d got %0d want %0d", i, d, vals[i]);
            end
        end
        apb_write(5, 16'h1); apb_read(5, d);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL stop_set got %h want 1", d); end
        apb_write(5, 16'h0); apb_read(5, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL stop_clr got %h want 0", d); end
    endtask

    task automatic test_basic_product();
        logic [15:0] d;
        int s, t;
        logic [7:0] exp_b[6] = '{8'hFB, 8'hFF, 8'hFF, 8'h0A, 8'h00, 8'h00};
        mem[100] = 8'd3; mem[101] = 8'd4; mem[200] = 8'd1; mem[201] = 8'd2;
        for (int i = 0; i < 6; i++) mem[300 + i] = 8'h55;
        program_run(100, 200, 300, 1);
        s = start_cyc + 1;
        apb_read(4, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL cfg_reads0 got %h want 0", d); end
        t = 0;
        while (cyc < s + P && t < 100) begin @(negedge clk); t++; end
        apb_read(6, d);
        checks++;
        if (d !== 16'd4) begin errors++; $display("FAIL basic_done_state got %0d want 4", d); end
        apb_read(5, d);
        checks++;
        if (d !== 16'd1) begin errors++; $display("FAIL basic_stop got %0d want 1", d); end
        apb_read(6, d);
        checks++;
        if (d !== 16'd0) begin errors++; $display("FAIL basic_idle got %0d want 0", d); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[300 + i] !== exp_b[i]) begin
                errors++; $display("FAIL basic_byte%0d got %h want %h", i, mem[300 + i], exp_b[i]);
            end
        end
        checks++;
        if (acc_log.size() != 10) begin
            errors++; $display("FAIL basic_accesses got %0d want 10", acc_log.size());
        end else begin
            checks++;
            if (acc_log[0].cyc != s || acc_log[4].cyc != s + 5 + M || acc_log[4].we !== 1'b1) begin
                errors++; $display("FAIL basic_timing got rd0=%0d wr0=%0d want rd0=%0d wr0=%0d",
                                   acc_log[0].cyc, acc_log[4].cyc, s, s + 5 + M);
            end
        end
    endtask

    task automatic test_extreme();
        logic [15:0] d;
        int t;
        logic [7:0] exp_b[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
        mem[400] = 8'h80; mem[401] = 8'h80; mem[500] = 8'h80; mem[501] = 8'h80;
        for (int i = 0; i < 6; i++) mem[600 + i] = 8'hAA;
        program_run(400, 500, 600, 1);
        t = 0;
        do begin apb_read(5, d); t++; end while (d[0] !== 1'b1 && t < 100);
        checks++;
        if (d[0] !== 1'b1) begin errors++; $display("FAIL extreme_timeout got stop=%b want 1", d[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[600 + i] !== exp_b[i]) begin
                errors++; $display("FAIL extreme_byte%0d got %h want %h", i, mem[600 + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_random_ops();
        logic [15:0] dst, dsp;
        bit seen[8];
        int s, n;
        logic [47:0] r;
        int exp_cyc, exp_addr;
        logic exp_we;
        for (int i = 0; i < 20; i++) begin
            mem[1000 + i] = 8'($urandom);
            mem[2000 + i] = 8'($urandom);
        end
        mem[1000] = 8'h80; mem[2001] = 8'h7F;
        for (int i = 0; i < 60; i++) mem[3000 + i] = 8'h5A;
        program_run(1000, 2000, 3000, 10);
        s = start_cyc + 1;
        n = 0;
        dsp = '0; dst = '0;
        while (n < 100) begin
            apb_read(5, dsp);
            apb_read(6, dst);
            seen[dst[2:0]] = 1'b1;
            n++;
            if (dsp[0] === 1'b1) break;
            repeat (3) @(negedge clk);
        end
        checks++;
        if (dsp[0] !== 1'b1 || dst !== 16'h0) begin
            errors++; $display("FAIL rand_end got stop=%b state=%0d want stop=1 state=0", dsp[0], dst);
        end
        checks++;
        if (!(seen[1] && seen[2] && seen[3])) begin
            errors++; $display("FAIL rand_states got rd=%b mul=%b wr=%b want 111", seen[1], seen[2], seen[3]);
        end
        for (int k = 0; k < 10; k++) begin
            r = ref_res(1000 + 2 * k, 2000 + 2 * k);
            for (int b = 0; b < 6; b++) begin
                checks++;
                if (mem[3000 + 6 * k + b] !== r[8 * b +: 8]) begin
                    errors++; $display("FAIL rand_op%0d_byte%0d got %h want %h", k, b, mem[3000 + 6 * k + b], r[8 * b +: 8]);
                end
            end
        end
        checks++;
        if (acc_log.size() != 100) begin
            errors++; $display("FAIL rand_accesses got %0d want 100", acc_log.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                for (int i = 0; i < 10; i++) begin
                    exp_we   = (i >= 4);
                    exp_cyc  = s + k * P + ((i < 4) ? i : 5 + M + i - 4);
                    exp_addr = (i < 2) ? 1000 + 2 * k + i : (i < 4) ? 2000 + 2 * k + i - 2 : 3000 + 6 * k + i - 4;
                    checks++;
                    if (acc_log[k * 10 + i].cyc != exp_cyc || acc_log[k * 10 + i].addr !== 16'(exp_addr) ||
                        acc_log[k * 10 + i].we !== exp_we) begin
                        errors++;
                        $display("FAIL rand_access%0d got cyc=%0d addr=%0d we=%b want cyc=%0d addr=%0d we=%b",
                                 k * 10 + i, acc_log[k * 10 + i].cyc, acc_log[k * 10 + i].addr,
                                 acc_log[k * 10 + i].we, exp_cyc, exp_addr, exp_we);
                    end
                end
            end
        end
    endtask

    task automatic test_slverr();
        logic [15:0] d; logic r, e;
        int shadow[6] = '{1000, 2000, 3000, 10, 0, 1};
        apb_xfer(1'b1, 69, 16'hDEAD, d, r, e);
        checks++;
        if (e !== EXP_ERR || r !== 1'b1) begin
            errors++; $display("FAIL slverr_wr got err=%b rdy=%b want err=%b rdy=1", e, r, EXP_ERR);
        end
        @(negedge clk);
        checks++;
        if (apb_pslverr !== 1'b0) begin errors++; $display("FAIL slverr_next got %b want 0", apb_pslverr); end
        apb_xfer(1'b1, -1, 16'hDEAD, d, r, e);
        checks++;
        if (e !== EXP_ERR) begin errors++; $display("FAIL slverr_below got %b want %b", e, EXP_ERR); end
        apb_xfer(1'b0, 7, 16'h0, d, r, e);
        checks++;
        if (e !== EXP_ERR || d !== 16'h0) begin
            errors++; $display("FAIL slverr_rd got err=%b d=%h want err=%b d=0", e, d, EXP_ERR);
        end
        for (int i = 0; i < 6; i++) begin
            apb_read(i, d);
            checks++;
            if (d !== 16'(shadow[i])) begin
                errors++; $display("FAIL slverr_keep%0d got %0d want %0d", i, d, shadow[i]);
            end
        end
    endtask

    task automatic test_nr_op_zero();
        logic [15:0] d;
        program_run(1000, 2000, 3000, 0);
        apb_read(6, d);
        checks++;
        if (d !== 16'd4) begin errors++; $display("FAIL zero_done got %0d want 4", d); end
        apb_read(5, d);
        checks++;
        if (d !== 16'd1) begin errors++; $display("FAIL zero_stop got %0d want 1", d); end
        repeat (10) @(negedge clk);
        checks++;
        if (acc_log.size() != 0) begin errors++; $display("FAIL zero_memce got %0d want 0", acc_log.size()); end
    endtask

    task automatic test_sw_rst();
        logic [15:0] d;
        int t;
        program_run(1000, 2000, 3000, 2);
        t = 0;
        while (mem_we !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL swrst_wait got we=%b want 1", mem_we); end
        repeat (2) @(negedge clk);
        sw_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({apb_pready, apb_pslverr, apb_prdata, mem_ce, mem_we, mem_addr, mem_wr_data} !== 44'h0) begin
            errors++; $display("FAIL swrst_outputs got %h want 0",
                               {apb_pready, apb_pslverr, apb_prdata, mem_ce, mem_we, mem_addr, mem_wr_data});
        end
        sw_rst = 1'b0;
        acc_log.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (acc_log.size() != 0) begin errors++; $display("FAIL swrst_memce got %0d want 0", acc_log.size()); end
        apb_read(6, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL swrst_state got %0d want 0", d); end
        apb_read(3, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL swrst_nrop got %0d want 0", d); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_regs();
        test_basic_product();
        test_extreme();
        test_random_ops();
        test_slverr();
        test_nr_op_zero();
        test_sw_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
